// File: rtl/test_pattern_engine.sv
// Test pattern generator: streams RGB565 frames (colour bars, gradient, checker, solid)
// over a valid/ready link, with a start-of-frame flag carried in out_data[16].
module test_pattern_engine #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int NUM_BARS     = 10,
  parameter int CHECK_LOG2   = 5,
  parameter int FRAME_GAP    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic [16:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int XW = 11;
  localparam logic [XW-1:0] X_LAST   = XW'(FRAME_WIDTH - 1);
  localparam logic [XW-1:0] Y_LAST   = XW'(FRAME_HEIGHT - 1);
  localparam logic [XW-1:0] BW_LAST  = XW'(FRAME_WIDTH / NUM_BARS - 1);
  localparam logic [3:0]    BAR_LAST = 4'(NUM_BARS - 1);
  localparam logic [7:0]    GAP_LAST = 8'(FRAME_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [XW-1:0] r_x, r_y, r_inbar;
  logic [3:0]    r_bar;
  logic [1:0]    r_mode;
  logic [15:0]   r_color;
  logic [7:0]    r_gap;
  logic [16:0]   r_out_data;
  logic          r_frame_done;
  logic [15:0]   r_frame_count;

  logic [XW-1:0] w_x_nxt, w_y_nxt, w_inbar_nxt;
  logic [3:0]    w_bar_nxt;
  logic          w_xfer, w_last_px, w_gap_end, w_latch, w_load, w_sof;
  logic [1:0]    w_mode_use;
  logic [15:0]   w_color_use, w_pix;

  function automatic logic [15:0] bar_color(input logic [3:0] idx);
    case (idx)
      4'd0:    bar_color = 16'hFFFF;
      4'd1:    bar_color = 16'hFFE0;
      4'd2:    bar_color = 16'h07FF;
      4'd3:    bar_color = 16'h07E0;
      4'd4:    bar_color = 16'hF81F;
      4'd5:    bar_color = 16'hF800;
      4'd6:    bar_color = 16'h001F;
      4'd7:    bar_color = 16'h0000;
      4'd8:    bar_color = 16'h8410;
      4'd9:    bar_color = 16'hFD20;
      4'd10:   bar_color = 16'h4208;
      4'd11:   bar_color = 16'hC618;
      4'd12:   bar_color = 16'h0010;
      4'd13:   bar_color = 16'h8000;
      4'd14:   bar_color = 16'h8400;
      default: bar_color = 16'h0410;
    endcase
  endfunction

  function automatic logic [15:0] pixel_of(input logic [1:0] m, input logic [15:0] c,
                                           input logic [XW-1:0] x, input logic [XW-1:0] y,
                                           input logic [3:0] bar);
    logic [XW-1:0] t;
    t = (x ^ y) >> CHECK_LOG2;
    case (m)
      2'd0:    pixel_of = bar_color(bar);
      2'd1:    pixel_of = {x[8:4], y[8:3], ~x[8:4]};
      2'd2:    pixel_of = t[0] ? 16'hFFFF : 16'h0000;
      default: pixel_of = c;
    endcase
  endfunction

  assign w_xfer    = (r_state == S_ACTIVE) && out_ready;
  assign w_last_px = w_xfer && (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_gap_end = (r_state == S_GAP) && (r_gap == GAP_LAST);
  assign w_latch   = enable && ((r_state == S_IDLE) || w_gap_end);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (enable) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_last_px) w_state_nxt = S_GAP;
      S_GAP:    if (w_gap_end) w_state_nxt = enable ? S_ACTIVE : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Bar position follows x with a bar/in-bar counter pair; the last bar absorbs the remainder.
  always_comb begin
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_bar_nxt   = r_bar;
    w_inbar_nxt = r_inbar;
    if (w_latch) begin
      w_x_nxt     = '0;
      w_y_nxt     = '0;
      w_bar_nxt   = '0;
      w_inbar_nxt = '0;
    end else if (w_xfer) begin
      if (r_x == X_LAST) begin
        w_x_nxt     = '0;
        w_bar_nxt   = '0;
        w_inbar_nxt = '0;
        w_y_nxt     = (r_y == Y_LAST) ? '0 : r_y + 1'b1;
      end else begin
        w_x_nxt = r_x + 1'b1;
        if (r_bar != BAR_LAST) begin
          if (r_inbar == BW_LAST) begin
            w_bar_nxt   = r_bar + 1'b1;
            w_inbar_nxt = '0;
          end else begin
            w_inbar_nxt = r_inbar + 1'b1;
          end
        end
      end
    end
  end

  // The next pixel is computed from the post-transfer coordinates so it loads on the transfer edge.
  assign w_mode_use  = w_latch ? mode : r_mode;
  assign w_color_use = w_latch ? solid_color : r_color;
  assign w_pix       = pixel_of(w_mode_use, w_color_use, w_x_nxt, w_y_nxt, w_bar_nxt);
  assign w_sof       = (w_x_nxt == '0) && (w_y_nxt == '0);
  assign w_load      = w_latch || (w_xfer && !w_last_px);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_bar         <= '0;
      r_inbar       <= '0;
      r_mode        <= '0;
      r_color       <= '0;
      r_gap         <= '0;
      r_out_data    <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_bar   <= w_bar_nxt;
      r_inbar <= w_inbar_nxt;
      if (w_latch) begin
        r_mode  <= mode;
        r_color <= solid_color;
      end
      if (w_load) r_out_data <= {w_sof, w_pix};
      r_gap         <= (r_state == S_GAP) ? r_gap + 8'd1 : 8'd0;
      r_frame_done  <= w_last_px;
      if (w_last_px) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = (r_state == S_ACTIVE);
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_test_pattern_engine.sv
// Bench for test_pattern_engine: whole frames checked against an arithmetic pattern model,
// plus fixed pixel vectors and hand sequences for gap, enable drop and mid-frame reset.
module tb_test_pattern_engine;

  localparam int W    = 100;
  localparam int H    = 12;
  localparam int NB   = 3;
  localparam int CL   = 2;
  localparam int GAP  = 4;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic [16:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        frame_done;
  logic [15:0] frame_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_fc  = 0;

  logic [16:0] cap [0:4][0:H-1][0:W-1];

  typedef struct {
    int          slot;
    int          x;
    int          y;
    logic [16:0] exp;
  } vec_t;
  vec_t vt [16];

  test_pattern_engine #(
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .NUM_BARS(NB), .CHECK_LOG2(CL), .FRAME_GAP(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .solid_color(solid_color),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bar_ref(input int i);
    logic [15:0] t [16];
    t = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000,
          16'h8410, 16'hFD20, 16'h4208, 16'hC618, 16'h0010, 16'h8000, 16'h8400, 16'h0410};
    return t[i];
  endfunction

  function automatic logic [15:0] ref_pixel(input int m, input logic [15:0] c, input int x, input int y);
    int idx, r, g, b;
    case (m)
      0: begin
        idx = x / (W / NB);
        if (idx > NB - 1) idx = NB - 1;
        return bar_ref(idx);
      end
      1: begin
        r = (x / 16) % 32;
        g = (y / 8) % 64;
        b = 31 - r;
        return 16'((r << 11) | (g << 5) | b);
      end
      2: return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return c;
    endcase
  endfunction

  // Streams one frame, comparing every pixel with the model and watching stall stability.
  task automatic run_frame(input int em, input logic [15:0] ec, input bit rnd, input int slot,
                           input int chg_at, input logic [1:0] cm, input logic [15:0] cc,
                           input int drop_at);
    int x, y, n, w, cyc, bad, badv, unstable;
    logic [16:0] exp, prev, fexp, fgot;
    bit prev_stall, r;
    x = 0; y = 0; n = 0; w = 0; cyc = 0; bad = 0; badv = 0; unstable = 0;
    prev = '0; prev_stall = 1'b0; fexp = '0; fgot = '0;
    while (!out_valid && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("frame_start_valid", {31'd0, out_valid}, 32'd1);
    while (n < NPIX && cyc < 20 * NPIX) begin
      if (!out_valid) badv++;
      else begin
        exp = {(x == 0 && y == 0), ref_pixel(em, ec, x, y)};
        if (out_data !== exp) begin
          if (bad == 0) begin fexp = exp; fgot = out_data; end
          bad++;
        end
        if (prev_stall && out_data !== prev) unstable++;
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready  = r;
      prev       = out_data;
      prev_stall = out_valid && !r;
      if (out_valid && r) begin
        if (slot >= 0) cap[slot][y][x] = out_data;
        n++;
        if (x == W - 1) begin x = 0; y++; end
        else x++;
        if (n == chg_at) begin mode = cm; solid_color = cc; end
        if (n == drop_at) enable = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    exp_fc = (exp_fc + 1) % 65536;
    check("frame_transfers", n, NPIX);
    check($sformatf("frame_pixels mode%0d first_bad(exp %h got %h)", em, fexp, fgot), bad, 0);
    check("frame_valid_dropout", badv, 0);
    check("stall_stability", unstable, 0);
    check("end_valid_low", {31'd0, out_valid}, 32'd0);
    check("frame_done_pulse", {31'd0, frame_done}, 32'd1);
    check("frame_count", {16'd0, frame_count}, exp_fc);
  endtask

  // Called on the first idle cycle after a frame; expects enable still high.
  task automatic measure_gap();
    int low, dn;
    low = 1; dn = 0;
    @(negedge clk);
    while (!out_valid && low < 300) begin
      if (frame_done) dn++;
      low++;
      @(negedge clk);
    end
    check("gap_length", low, GAP);
    check("frame_done_single", dn, 0);
  endtask

  task automatic expect_idle(input int cycles);
    int v, dn;
    v = 0; dn = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) v++;
      if (frame_done) dn++;
    end
    check("idle_no_valid", v, 0);
    check("idle_no_frame_done", dn, 0);
  endtask

  initial begin
    int diffs, cnt, g;
    logic [1:0]  cur_m, nxt_m;
    logic [15:0] cur_c, nxt_c;

    vt[0]  = '{0,  0,  0, 17'h1FFFF};
    vt[1]  = '{0, 32,  0, 17'h0FFFF};
    vt[2]  = '{0, 33,  0, 17'h0FFE0};
    vt[3]  = '{0, 65,  3, 17'h0FFE0};
    vt[4]  = '{0, 66,  3, 17'h007FF};
    vt[5]  = '{0, 99, 11, 17'h007FF};
    vt[6]  = '{1,  0,  0, 17'h1001F};
    vt[7]  = '{1, 99, 11, 17'h03039};
    vt[8]  = '{1, 16,  8, 17'h0083E};
    vt[9]  = '{1, 40,  5, 17'h0101D};
    vt[10] = '{2,  4,  0, 17'h0FFFF};
    vt[11] = '{2,  4,  4, 17'h00000};
    vt[12] = '{2,  0,  5, 17'h0FFFF};
    vt[13] = '{2,  7,  7, 17'h00000};
    vt[14] = '{3, 50,  6, 17'h01234};
    vt[15] = '{3, 99, 11, 17'h01234};

    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {15'd0, out_data}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    reset_n = 1'b1;
    expect_idle(5);

    mode = 2'd0; enable = 1'b1;
    run_frame(0, 16'h0, 1'b0, 0, -1, 2'd0, 16'h0, -1);
    mode = 2'd1;
    measure_gap();
    run_frame(1, 16'h0, 1'b0, 1, -1, 2'd0, 16'h0, -1);
    mode = 2'd2;
    measure_gap();
    run_frame(2, 16'h0, 1'b0, 2, -1, 2'd0, 16'h0, -1);
    mode = 2'd3; solid_color = 16'h1234;
    measure_gap();
    run_frame(3, 16'h1234, 1'b0, 3, 300, 2'd3, 16'hABCD, -1);
    measure_gap();
    run_frame(3, 16'hABCD, 1'b0, -1, -1, 2'd0, 16'h0, -1);
    mode = 2'd0;
    measure_gap();
    run_frame(0, 16'h0, 1'b1, 4, -1, 2'd0, 16'h0, 1000);
    expect_idle(40);

    diffs = 0;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        if (cap[4][yy][xx] !== cap[0][yy][xx]) diffs++;
    check("stall_sequence_matches", diffs, 0);

    for (int i = 0; i < 16; i++)
      check($sformatf("vec%0d slot%0d (%0d,%0d)", i, vt[i].slot, vt[i].x, vt[i].y),
            {15'd0, cap[vt[i].slot][vt[i].y][vt[i].x]}, {15'd0, vt[i].exp});

    cur_m = 2'($urandom_range(0, 3));
    cur_c = 16'($urandom);
    mode = cur_m; solid_color = cur_c; enable = 1'b1;
    for (int f = 0; f < 4; f++) begin
      nxt_m = 2'($urandom_range(0, 3));
      nxt_c = 16'($urandom);
      run_frame(int'(cur_m), cur_c, 1'b1, -1, int'($urandom_range(1, NPIX - 1)), nxt_m, nxt_c,
                (f == 3) ? 10 : -1);
      if (f != 3) measure_gap();
      cur_m = nxt_m; cur_c = nxt_c;
    end
    expect_idle(30);

    mode = 2'd0; enable = 1'b1; out_ready = 1'b1;
    cnt = 0; g = 0;
    while (cnt < 500 && g < 5000) begin
      @(negedge clk);
      if (out_valid) cnt++;
      g++;
    end
    check("pre_reset_progress", cnt, 500);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_frame_count", {16'd0, frame_count}, 32'd0);
    check("midrst_data", {15'd0, out_data}, 32'd0);
    @(negedge clk);
    check("midrst_hold_valid", {31'd0, out_valid}, 32'd0);
    reset_n = 1'b1;
    exp_fc = 0;
    run_frame(0, 16'h0, 1'b0, -1, -1, 2'd0, 16'h0, 1);
    expect_idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
